// File: rtl/mem_arbiter.sv
// Two-port arbiter and three-phase sequencer (ADDR, DATA, DONE) for the single-port data RAM.
// Port 0 is the CPU control unit; port 1 is the loader/debug port and can lock a burst.
module mem_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_lock1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_grant,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_ramAddress,
  output logic              o_ramAddressEn,
  output logic [DATA_W-1:0] o_ramWriteData,
  output logic              o_ramWriteEn,
  output logic              o_ramOE,
  input  logic [DATA_W-1:0] i_ramReadData
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t            state_r, nextState_s;
  logic              owner_r, lastServed_r, we_r;
  logic [ADDR_W-1:0] addr_r, ramAddress_r;
  logic [DATA_W-1:0] wdata_r, ramWriteData_r, rdata_r;
  logic [1:0]        grant_r;
  logic              ack0_r, ack1_r, ramAddressEn_r, ramWriteEn_r, ramOE_r;
  logic              load_s, loadPort_s, winner_s, selWe_s;
  logic [ADDR_W-1:0] selAddr_s;
  logic [DATA_W-1:0] selWdata_s;

  // Tie-break: fixed priority favours port 1, otherwise the port not served last.
  always_comb begin
    winner_s = 1'b0;
    if (i_req0 && i_req1) begin
      if (FIXED_PRIO != 32'sd0) begin
        winner_s = 1'b1;
      end else begin
        winner_s = ~lastServed_r;
      end
    end else begin
      winner_s = i_req1;
    end
  end

  // Next-state logic and request capture decision.
  always_comb begin
    nextState_s = state_r;
    load_s      = 1'b0;
    loadPort_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req0 || i_req1) begin
          load_s      = 1'b1;
          loadPort_s  = winner_s;
          nextState_s = ADDR;
        end else begin
          nextState_s = IDLE;
        end
      end
      ADDR: nextState_s = DATA;
      DATA: nextState_s = DONE;
      DONE: begin
        // A locked port-1 owner chains straight into its next access.
        if (i_lock1 && owner_r && i_req1) begin
          load_s      = 1'b1;
          loadPort_s  = 1'b1;
          nextState_s = ADDR;
        end else begin
          nextState_s = IDLE;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Winner's request fields, selected for capture.
  always_comb begin
    selWe_s    = loadPort_s ? i_we1    : i_we0;
    selAddr_s  = loadPort_s ? i_addr1  : i_addr0;
    selWdata_s = loadPort_s ? i_wdata1 : i_wdata0;
  end

  // State, latched request and registered RAM strobes aligned with the next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r        <= IDLE;
      owner_r        <= 1'b0;
      lastServed_r   <= 1'b1;
      we_r           <= 1'b0;
      addr_r         <= {ADDR_W{1'b0}};
      wdata_r        <= {DATA_W{1'b0}};
      grant_r        <= 2'b00;
      ack0_r         <= 1'b0;
      ack1_r         <= 1'b0;
      ramAddress_r   <= {ADDR_W{1'b0}};
      ramAddressEn_r <= 1'b0;
      ramWriteData_r <= {DATA_W{1'b0}};
      ramWriteEn_r   <= 1'b0;
      ramOE_r        <= 1'b0;
      rdata_r        <= {DATA_W{1'b0}};
    end else begin
      state_r <= nextState_s;
      if (load_s) begin
        owner_r      <= loadPort_s;
        lastServed_r <= loadPort_s;
        we_r         <= selWe_s;
        addr_r       <= selAddr_s;
        wdata_r      <= selWdata_s;
      end
      if (nextState_s == IDLE) begin
        grant_r <= 2'b00;
      end else if (load_s) begin
        grant_r <= loadPort_s ? 2'b10 : 2'b01;
      end
      ramAddressEn_r <= (nextState_s == ADDR);
      if (nextState_s == ADDR) begin
        ramAddress_r <= selAddr_s;
      end
      ramWriteEn_r <= (nextState_s == DATA) && we_r;
      ramOE_r      <= (nextState_s == DATA) && !we_r;
      if ((nextState_s == DATA) && we_r) begin
        ramWriteData_r <= wdata_r;
      end
      ack0_r <= (nextState_s == DONE) && !owner_r;
      ack1_r <= (nextState_s == DONE) && owner_r;
      if ((state_r == DATA) && !we_r) begin
        rdata_r <= i_ramReadData;
      end
    end
  end

  assign o_ack0         = ack0_r;
  assign o_ack1         = ack1_r;
  assign o_rdata        = rdata_r;
  assign o_grant        = grant_r;
  assign o_busy         = (state_r != IDLE);
  assign o_ramAddress   = ramAddress_r;
  assign o_ramAddressEn = ramAddressEn_r;
  assign o_ramWriteData = ramWriteData_r;
  // Gating with reset keeps a write aborted in DATA from landing on the reset edge.
  assign o_ramWriteEn   = ramWriteEn_r & ~i_reset;
  assign o_ramOE        = ramOE_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural RAM, expected acks queued at stimulus time
// and popped on every ack; a second instance exercises fixed priority.
module tb_mem_arbiter;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       req0, req1, we0, we1, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, busy, ramAddressEn, ramWriteEn, ramOE;
  logic [7:0] rdata, ramAddress, ramWriteData, ramReadData;
  logic [1:0] grant;

  logic       fReq0, fReq1, fAck0, fAck1, fBusy, fRamAddrEn, fRamWe, fRamOE;
  logic [7:0] fZero8, fRdata, fRamAddr, fRamWdata;
  logic [1:0] fGrant;

  logic [7:0] mem [0:255];
  logic [7:0] ramAddrReg;
  logic       bdEn;
  logic [7:0] bdAddr, bdData;

  typedef struct packed {logic port; logic isRead; logic [7:0] data;} exp_t;
  exp_t sbQ[$];
  exp_t e;
  int   ack1Cyc[$];
  int   total = 0, bad = 0, cyc = 0, weCnt = 0;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.DATA_W(8), .ADDR_W(8), .FIXED_PRIO(0)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_lock1(lock1), .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata),
    .o_grant(grant), .o_busy(busy), .o_ramAddress(ramAddress),
    .o_ramAddressEn(ramAddressEn), .o_ramWriteData(ramWriteData),
    .o_ramWriteEn(ramWriteEn), .o_ramOE(ramOE), .i_ramReadData(ramReadData)
  );

  mem_arbiter #(.DATA_W(8), .ADDR_W(8), .FIXED_PRIO(1)) uFix (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req0(fReq0), .i_req1(fReq1), .i_we0(1'b0), .i_we1(1'b0),
    .i_addr0(8'h01), .i_addr1(8'h02), .i_wdata0(8'h00), .i_wdata1(8'h00),
    .i_lock1(1'b0), .o_ack0(fAck0), .o_ack1(fAck1), .o_rdata(fRdata),
    .o_grant(fGrant), .o_busy(fBusy), .o_ramAddress(fRamAddr),
    .o_ramAddressEn(fRamAddrEn), .o_ramWriteData(fRamWdata),
    .o_ramWriteEn(fRamWe), .o_ramOE(fRamOE), .i_ramReadData(fZero8)
  );

  // RAM model: address register loaded on AddressEn, write on WriteEn, backdoor preload.
  always @(posedge i_clk) begin
    if (bdEn) mem[bdAddr] <= bdData;
    else if (ramWriteEn) mem[ramAddrReg] <= ramWriteData;
    if (ramAddressEn) ramAddrReg <= ramAddress;
  end
  assign ramReadData = mem[ramAddrReg];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: strobe exclusivity every cycle; scoreboard pop on each ack.
  always @(posedge i_clk) begin
    #1;
    checkEq("strobe_excl", {31'd0, ($countones({ramAddressEn, ramWriteEn, ramOE}) <= 1)}, 32'd1);
    if (ramWriteEn) weCnt++;
    if (ack0 || ack1) begin
      if (ack1) ack1Cyc.push_back(cyc);
      if (sbQ.size() == 0) begin
        checkEq("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkEq("ack_port", {30'd0, ack1, ack0}, e.port ? 32'd2 : 32'd1);
        if (e.isRead) checkEq("rdata", {24'd0, rdata}, {24'd0, e.data});
      end
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge i_clk);
    bdEn = 1'b1; bdAddr = a; bdData = d;
  endtask

  task automatic waitAddrEn();
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge i_clk); #1;
      if (ramAddressEn) found = 1'b1;
    end
    if (!found) checkEq("addrEn_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitAck(input bit port);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge i_clk); #1;
      if (port ? ack1 : ack0) found = 1'b1;
    end
    if (!found) checkEq("ack_timeout", {31'd0, port}, 32'hFF);
  endtask

  task automatic waitFix(output bit port);
    bit found = 1'b0;
    port = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge i_clk); #1;
      if (fAck0 || fAck1) begin found = 1'b1; port = fAck1; end
    end
    if (!found) checkEq("fix_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic doAccess(input bit port, input bit we, input logic [7:0] a,
                          input logic [7:0] d, input bit pushIt, input logic [7:0] expData);
    @(negedge i_clk);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    if (pushIt) sbQ.push_back('{port, !we, expData});
    waitAddrEn();
    @(negedge i_clk);
    if (port) req1 = 1'b0; else req0 = 1'b0;
    waitAck(port);
  endtask

  initial begin
    bit p;
    int w0;
    i_reset = 1'b1; bdEn = 1'b0; bdAddr = 8'h00; bdData = 8'h00;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    fReq0 = 1'b0; fReq1 = 1'b0; fZero8 = 8'h00;
    load(8'h10, 8'hA5); load(8'h11, 8'h5A); load(8'h40, 8'h11); load(8'h05, 8'h55);
    load(8'h06, 8'h66); load(8'h00, 8'hB0); load(8'h01, 8'hB1); load(8'h02, 8'hB2);
    load(8'h03, 8'hB3); load(8'h20, 8'h00);
    @(negedge i_clk); bdEn = 1'b0;
    @(posedge i_clk); #1;
    checkEq("rst_grant", {30'd0, grant}, 32'd0);
    checkEq("rst_strobes", {29'd0, ramAddressEn, ramWriteEn, ramOE}, 32'd0);
    checkEq("rst_acks_busy", {29'd0, ack0, ack1, busy}, 32'd0);
    checkEq("rst_regs", {8'd0, ramAddress, ramWriteData, rdata}, 32'd0);
    @(negedge i_clk); i_reset = 1'b0;

    // Round robin from reset: port 0 wins the first tie, then alternate.
    @(negedge i_clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h11;
    sbQ.push_back('{1'b0, 1'b1, 8'hA5}); sbQ.push_back('{1'b1, 1'b1, 8'h5A});
    sbQ.push_back('{1'b0, 1'b1, 8'hA5}); sbQ.push_back('{1'b1, 1'b1, 8'h5A});
    waitAck(1'b0); waitAck(1'b1); waitAck(1'b0); waitAck(1'b1);
    @(negedge i_clk); req0 = 1'b0; req1 = 1'b0;
    @(posedge i_clk); #1;

    // Single read with cycle-accurate strobe and grant checks.
    @(negedge i_clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    sbQ.push_back('{1'b0, 1'b1, 8'hA5});
    @(posedge i_clk); #1;
    checkEq("rd_t1_addrEn", {31'd0, ramAddressEn}, 32'd1);
    checkEq("rd_t1_addr", {24'd0, ramAddress}, 32'h10);
    checkEq("rd_t1_grant_busy", {29'd0, grant, busy}, 32'b011);
    checkEq("rd_t1_oe", {31'd0, ramOE}, 32'd0);
    @(negedge i_clk); req0 = 1'b0;
    @(posedge i_clk); #1;
    checkEq("rd_t2_oe_addrEn", {30'd0, ramOE, ramAddressEn}, 32'b10);
    checkEq("rd_t2_grant", {30'd0, grant}, 32'd1);
    @(posedge i_clk); #1;
    checkEq("rd_t3_ack0", {30'd0, ack0, ack1}, 32'b10);
    checkEq("rd_t3_grant", {30'd0, grant}, 32'd1);
    checkEq("rd_t3_strobes", {29'd0, ramAddressEn, ramWriteEn, ramOE}, 32'd0);
    @(posedge i_clk); #1;
    checkEq("rd_idle_grant_busy", {29'd0, grant, busy}, 32'd0);

    // Address change after the grant is ignored.
    @(negedge i_clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    sbQ.push_back('{1'b0, 1'b1, 8'h55});
    waitAddrEn();
    checkEq("latch_addr_t1", {24'd0, ramAddress}, 32'h05);
    @(negedge i_clk); addr0 = 8'h06; req0 = 1'b0;
    @(posedge i_clk); #1;
    checkEq("latch_addr_t2", {24'd0, ramAddress}, 32'h05);
    waitAck(1'b0);

    // Port 1 write then read; write leaves o_rdata alone and pulses WriteEn once.
    w0 = weCnt;
    doAccess(1'b1, 1'b1, 8'h20, 8'h3C, 1'b1, 8'h00);
    checkEq("we_pulses", weCnt - w0, 32'd1);
    checkEq("rdata_after_write", {24'd0, rdata}, 32'h55);
    checkEq("ram_written", {24'd0, mem[8'h20]}, 32'h3C);
    doAccess(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h3C);

    // Locked burst on port 1 with port 0 waiting.
    ack1Cyc.delete();
    @(negedge i_clk);
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 8'h00;
    for (int i = 0; i < 4; i++) sbQ.push_back('{1'b1, 1'b1, 8'hB0 + 8'(i)});
    sbQ.push_back('{1'b0, 1'b1, 8'hA5});
    for (int i = 0; i < 4; i++) begin
      waitAddrEn();
      checkEq("lock_grant", {30'd0, grant}, 32'd2);
      @(negedge i_clk);
      if (i == 0) begin req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; end
      if (i < 3) addr1 = 8'(i + 1);
      else begin req1 = 1'b0; lock1 = 1'b0; end
    end
    waitAddrEn();
    checkEq("after_lock_grant", {30'd0, grant}, 32'd1);
    @(negedge i_clk); req0 = 1'b0;
    waitAck(1'b0);
    checkEq("lock_acks", ack1Cyc.size(), 32'd4);
    if (ack1Cyc.size() >= 4)
      for (int i = 0; i < 3; i++) checkEq("lock_gap", ack1Cyc[i + 1] - ack1Cyc[i], 32'd3);

    // Reset during DATA of a write: aborted, no ack, RAM keeps its old value.
    @(negedge i_clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h99;
    waitAddrEn();
    @(negedge i_clk); req0 = 1'b0;
    @(posedge i_clk); #1;
    checkEq("abort_we_in_data", {31'd0, ramWriteEn}, 32'd1);
    @(negedge i_clk); i_reset = 1'b1;
    @(posedge i_clk); #1;
    checkEq("abort_grant_busy", {29'd0, grant, busy}, 32'd0);
    checkEq("abort_strobes", {29'd0, ramAddressEn, ramWriteEn, ramOE}, 32'd0);
    checkEq("abort_acks", {30'd0, ack0, ack1}, 32'd0);
    checkEq("abort_rdata", {24'd0, rdata}, 32'd0);
    @(negedge i_clk); i_reset = 1'b0;
    doAccess(1'b0, 1'b0, 8'h40, 8'h00, 1'b1, 8'h11);

    // Fixed priority instance: port 1 wins every tie.
    @(negedge i_clk); fReq0 = 1'b1; fReq1 = 1'b1;
    waitFix(p); checkEq("fix_tie1", {31'd0, p}, 32'd1);
    waitFix(p); checkEq("fix_tie2", {31'd0, p}, 32'd1);
    @(negedge i_clk); fReq1 = 1'b0;
    waitFix(p); checkEq("fix_p0_after", {31'd0, p}, 32'd0);
    @(negedge i_clk); fReq0 = 1'b0;

    for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(posedge i_clk);
    #2;
    checkEq("sb_empty", sbQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
